// File: rtl/im_access_ctrl.sv
// Instruction memory access sequencer.
// Shares a byte-wide array between fetch reads and loader writes.
module im_access_ctrl #(
  parameter int MEM_SIZE = 128,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_done,
  output logic [31:0]       f_instr,
  output logic              f_err,
  input  logic              l_req,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_done,
  output logic              l_err,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state;
  logic [1:0]        beat;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata;
  logic [23:0]       sh;
  logic              gnt_l;
  logic              last_l;
  logic              err;
  logic              grant_f;
  logic              grant_l;
  logic              f_oor;
  logic              l_oor;
  logic              busy;

  // Arbitration: loader wins a tie only if fetch was granted last.
  always_comb begin
    grant_l = l_req && (!f_req || !last_l);
    grant_f = f_req && !grant_l;
    f_oor   = f_addr >= 32'(MEM_SIZE);
    l_oor   = l_addr >= 32'(MEM_SIZE);
  end

  // Sequencer: grant, four byte beats, one done cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      beat    <= 2'd0;
      base    <= '0;
      wdata   <= '0;
      sh      <= '0;
      gnt_l   <= 1'b0;
      last_l  <= 1'b1;
      err     <= 1'b0;
      f_instr <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          beat <= 2'd0;
          if (grant_f) begin
            gnt_l  <= 1'b0;
            last_l <= 1'b0;
            base   <= {f_addr[ADDR_W-1:2], 2'b00};
            err    <= f_oor;
            state  <= f_oor ? S_DONE : S_RD;
          end else if (grant_l) begin
            gnt_l  <= 1'b1;
            last_l <= 1'b1;
            base   <= {l_addr[ADDR_W-1:2], 2'b00};
            wdata  <= l_wdata;
            err    <= l_oor;
            state  <= l_oor ? S_DONE : S_WR;
          end
        end
        S_RD: begin
          sh   <= {sh[15:0], mem_rdata};
          beat <= beat + 2'd1;
          if (beat == 2'd3) begin
            f_instr <= {sh, mem_rdata};
            state   <= S_DONE;
          end
        end
        S_WR: begin
          beat <= beat + 2'd1;
          if (beat == 2'd3) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
      endcase
    end
  end

  // Memory side: address and write byte only while beating.
  always_comb begin
    busy      = (state == S_RD) || (state == S_WR);
    mem_we    = (state == S_WR);
    mem_addr  = busy ? (base | {{(ADDR_W-2){1'b0}}, beat}) : '0;
    mem_wdata = 8'h00;
    if (mem_we) begin
      unique case (beat)
        2'd0: mem_wdata = wdata[31:24];
        2'd1: mem_wdata = wdata[23:16];
        2'd2: mem_wdata = wdata[15:8];
        2'd3: mem_wdata = wdata[7:0];
      endcase
    end
  end

  // Completion pulses go to whichever side holds the grant.
  always_comb begin
    f_done = (state == S_DONE) && !gnt_l;
    l_done = (state == S_DONE) && gnt_l;
    f_err  = f_done && err;
    l_err  = l_done && err;
  end

endmodule

// File: doc/im_access_ctrl.md
Name: im_access_ctrl

Overview:
- Sequences and shares the byte-wide instruction memory (128 B, big-endian, one byte per access) between two requesters: the CPU fetch port (word reads) and the program loader/debug port (word writes).
- Each word access is four byte beats; the controller assembles or splits big-endian words.
- Sits between the fetch stage / loader and the instruction byte array.

Parameters:
- MEM_SIZE, 128, instruction memory size in bytes (multiple of 4).
- ADDR_W, 7, memory byte-address width; equals log2(MEM_SIZE).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch request level; held until f_done.
- f_addr  in  32  fetch byte address; bits [1:0] ignored.
- f_done  out  1  one-cycle pulse; f_instr/f_err valid.
- f_instr  out  32  fetched word, big-endian.
- f_err  out  1  with f_done: address out of range.
- l_req  in  1  loader write request level; held until l_done.
- l_addr  in  32  loader byte address; bits [1:0] ignored.
- l_wdata  in  32  loader word to write, big-endian.
- l_done  out  1  one-cycle pulse; write finished.
- l_err  out  1  with l_done: address out of range, nothing written.
- mem_addr  out  ADDR_W  byte address to memory.
- mem_rdata  in  8  combinational read data at mem_addr.
- mem_we  out  1  byte write enable; memory writes on rising clk.
- mem_wdata  out  8  byte to write.

Behaviour:
- States: IDLE, RD, WR, DONE.
- Reset (async, rst=0): state IDLE, beat=0, all outputs 0 (f_instr=0, mem_we=0 immediately), round-robin pointer set so fetch wins the first tie.
- Abort on reset: reset mid-transaction abandons it with no done pulse. A partially written word stays partially written.
- IDLE: at each edge sample f_req/l_req.
  - One request pending: grant it.
  - Both pending: grant the requester not granted last (round-robin).
  - Grant latches base = addr[ADDR_W-1:2]<<2 and, for writes, l_wdata.
- Out-of-range access (addr >= MEM_SIZE): go directly to DONE with the err flag set. No mem_we; f_instr is unchanged.
- RD beats 0..3:
  - mem_addr = base+beat.
  - At each edge shift mem_rdata into the word: beat 0 is [31:24], beat 3 is [7:0].
  - After beat 3, go to DONE.
- WR beats 0..3:
  - mem_we=1, mem_addr = base+beat, mem_wdata = wdata[31-8*beat -: 8].
  - After beat 3, go to DONE.
- mem_we is 1 only in WR. mem_addr is 0 in IDLE/DONE.
- DONE (one cycle): pulse the granted requester's done; err is valid in the same cycle; next state IDLE.
- Latency: grant edge, then 4 beat cycles, then done in the 5th cycle after the grant edge. In-range throughput is one word per 6 cycles.
- Back-to-back: a new request must be sampled in IDLE. The cycle after DONE is always IDLE.
- f_instr holds the last successfully read word until the next successful read.
- Handshake:
  - A requester clears req on the edge where it sees done high.
  - Dropping req mid-transaction does not cancel it; done is still pulsed.
  - Changing addr/wdata after the grant has no effect (values are latched).
- Never more than one of f_done/l_done is high. f_err=0 and l_err=0 whenever their done is low.

Test Plan:
- Fetch after reset: bytes at 0x10..0x13 = 12,34,56,78; f_req with f_addr=0x10 → mem_addr 0x10,0x11,0x12,0x13 on consecutive cycles; f_done in the 5th cycle; f_instr=0x12345678, f_err=0.
- Loader write then fetch: l_addr=0x7C, l_wdata=0xDEADBEEF → mem_we=1 for exactly 4 cycles with bytes DE,AD,BE,EF at 0x7C..0x7F; l_done pulse; a following fetch of 0x7D returns 0xDEADBEEF (unaligned address bits ignored).
- Simultaneous requests held high after reset → order is fetch, loader, fetch, loader; each done arrives 6 cycles after the previous one; no overlapping mem_we during reads.
- Out of range: f_addr=0x80 → f_done+f_err in the cycle after the grant; no mem activity; f_instr retains its prior value. l_addr=0x100 → l_err, memory unchanged.
- Reset mid-write: rst low during WR beat 2 → mem_we=0 immediately, no l_done, state IDLE; only bytes 0 and 1 are written. After release, a fetch completes normally.
- Drop req mid-read: f_req falls during beat 1 → f_done still pulses with the correct word. The next IDLE does not start a new read.
